icache: RTL and testbench

- Instruction cache; the responder end of the fetcher-to-ICache query interface.
- Direct-mapped and read-only, holding multi-word lines.
- On a hit it returns the instruction word one cycle after the query is sampled.
- On a miss it refills the whole line from the memory controller, one word request at a time, then responds.
- Sits between the instruction fetcher and the memory controller's instruction-read port.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_if.sv | 35 +++
 rtl/icache_line_array.sv | 69 ++++++
 rtl/icache.sv | 178 +++++++++++++++++
 tb/tb_icache.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache: controller state encoding and
// the default address-field widths used to split a fetch address into
// tag / index / word offset.
// No ports (package).
// ----------------------------------------------------------------------------
package icache_pkg;

  // Default geometry: 16 lines of 4 words (16 B per line).
  localparam int ICACHE_INDEX_WIDTH  = 4;
  localparam int ICACHE_OFFSET_WIDTH = 2;
  localparam int ICACHE_TAG_WIDTH    = 32 - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH - 2;

  // Cache controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// ----------------------------------------------------------------------------
// icache_if
// Bundled handshakes around the instruction cache.
//   icache_fetch_if : fetcher (master) <-> cache (slave)
//     query_en, query_pc, flush_in   fetcher -> cache
//     data_en, addr_confirm, data    cache -> fetcher
//   icache_mem_if   : cache (master) <-> memory controller (slave)
//     mem_req_en, mem_req_addr       cache -> memory
//     mem_resp_en, mem_resp_data     memory -> cache
// ----------------------------------------------------------------------------
interface icache_fetch_if;
  logic        query_en;
  logic [31:0] query_pc;
  logic        flush_in;
  logic        data_en;
  logic [31:0] addr_confirm;
  logic [31:0] data;

  modport master (output query_en, query_pc, flush_in,
                  input  data_en, addr_confirm, data);
  modport slave  (input  query_en, query_pc, flush_in,
                  output data_en, addr_confirm, data);
endinterface

interface icache_mem_if;
  logic        mem_req_en;
  logic [31:0] mem_req_addr;
  logic        mem_resp_en;
  logic [31:0] mem_resp_data;

  modport master (output mem_req_en, mem_req_addr,
                  input  mem_resp_en, mem_resp_data);
  modport slave  (input  mem_req_en, mem_req_addr,
                  output mem_resp_en, mem_resp_data);
endinterface

// File: rtl/icache_line_array.sv
// ----------------------------------------------------------------------------
// icache_line_array
// Valid / tag / data storage of the direct-mapped instruction cache.
//   clk_i        clock
//   clear_i      synchronous clear of every valid bit
//   rdIndex_i    read line index        rdOffset_i  read word offset
//   rdValid_o    valid bit of the line  rdTag_o     stored tag of the line
//   rdWord_o     stored word (combinational read)
//   wrEn_i       write one data word at wrIndex_i / wrOffset_i with wrData_i
//   setValid_i   mark line setIndex_i valid and store setTag_i as its tag
// ----------------------------------------------------------------------------
module icache_line_array import icache_pkg::*; #(
  parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = ICACHE_TAG_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  input  logic [INDEX_WIDTH-1:0]  rdIndex_i,
  input  logic [OFFSET_WIDTH-1:0] rdOffset_i,
  output logic                    rdValid_o,
  output logic [TAG_WIDTH-1:0]    rdTag_o,
  output logic [31:0]             rdWord_o,
  input  logic                    wrEn_i,
  input  logic [INDEX_WIDTH-1:0]  wrIndex_i,
  input  logic [OFFSET_WIDTH-1:0] wrOffset_i,
  input  logic [31:0]             wrData_i,
  input  logic                    setValid_i,
  input  logic [INDEX_WIDTH-1:0]  setIndex_i,
  input  logic [TAG_WIDTH-1:0]    setTag_i
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tags_q  [LINES];
  logic [31:0]          words_q [LINES][WORDS];

  // Valid bits are the only storage that needs a known value after reset;
  // clearing them is enough to make every stale tag/word unreachable.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= '0;
    end else if (setValid_i) begin
      valid_q[setIndex_i] <= 1'b1;
    end
  end

  // Tag is written together with the valid bit once the whole line is in.
  always_ff @(posedge clk_i) begin
    if (setValid_i) begin
      tags_q[setIndex_i] <= setTag_i;
    end
  end

  // One data word per refill beat.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      words_q[wrIndex_i][wrOffset_i] <= wrData_i;
    end
  end

  // Combinational read port used for the same-cycle tag compare.
  assign rdValid_o = valid_q[rdIndex_i];
  assign rdTag_o   = tags_q[rdIndex_i];
  assign rdWord_o  = words_q[rdIndex_i][rdOffset_i];

endmodule

// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache between the instruction fetcher
// and the memory controller's instruction-read port. Hits answer one cycle
// after the query is sampled; misses refill the whole line one word at a time
// and then answer.
//   clk_in   clock
//   rst_in   synchronous active-high reset (clears all valid bits, aborts refill)
//   rdy_in   global ready; low freezes every register
//   fetch    icache_fetch_if.slave  : query_en/query_pc/flush_in in,
//                                     data_en/addr_confirm/data out
//   mem      icache_mem_if.master   : mem_req_en/mem_req_addr out,
//                                     mem_resp_en/mem_resp_data in
// ----------------------------------------------------------------------------
module icache import icache_pkg::*; #(
  parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  icache_fetch_if.slave fetch,
  icache_mem_if.master  mem
);

  localparam int OFF_LO = 2;
  localparam int IDX_LO = OFFSET_WIDTH + 2;
  localparam int TAG_LO = OFFSET_WIDTH + INDEX_WIDTH + 2;
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  icache_state_e           state_q;
  logic [31:0]             pc_q;
  logic [OFFSET_WIDTH-1:0] counter_q;
  logic                    killed_q;
  logic [31:0]             respWord_q;
  logic                    dataEn_q;
  logic [31:0]             addrConfirm_q;
  logic [31:0]             data_q;
  logic                    memReqEn_q;
  logic [31:0]             memReqAddr_q;

  logic [INDEX_WIDTH-1:0]  qIndex;
  logic [OFFSET_WIDTH-1:0] qOffset;
  logic [TAG_WIDTH-1:0]    qTag;
  logic [INDEX_WIDTH-1:0]  pcIndex;
  logic [OFFSET_WIDTH-1:0] pcOffset;
  logic [TAG_WIDTH-1:0]    pcTag;
  logic                    rdValid;
  logic [TAG_WIDTH-1:0]    rdTag;
  logic [31:0]             rdWord;
  logic                    hit;
  logic                    accept;
  logic                    beat;
  logic                    lastBeat;
  logic [31:0]             lineBase;
  logic [OFFSET_WIDTH-1:0] counterInc;
  logic                    unusedPcBits;

  // Field split of the incoming query (lookup) and of the latched query
  // (refill target).
  assign qIndex   = fetch.query_pc[IDX_LO +: INDEX_WIDTH];
  assign qOffset  = fetch.query_pc[OFF_LO +: OFFSET_WIDTH];
  assign qTag     = fetch.query_pc[TAG_LO +: TAG_WIDTH];
  assign pcIndex  = pc_q[IDX_LO +: INDEX_WIDTH];
  assign pcOffset = pc_q[OFF_LO +: OFFSET_WIDTH];
  assign pcTag    = pc_q[TAG_LO +: TAG_WIDTH];
  assign unusedPcBits = ^fetch.query_pc[1:0];

  // A query still high in its own response cycle must not be looked up again,
  // hence the data_en term.
  assign accept   = fetch.query_en && !dataEn_q && !fetch.flush_in;
  assign hit      = rdValid && (rdTag == qTag);

  // A refill beat is a memory word arriving while the clock is enabled.
  // Flush does not gate it: the memory handshake always runs to completion.
  assign beat     = rdy_in && (state_q == REFILL) && mem.mem_resp_en;
  assign lastBeat = beat && (counter_q == LAST_WORD);

  assign lineBase   = {fetch.query_pc[31:IDX_LO], {(OFFSET_WIDTH + 2){1'b0}}};
  assign counterInc = counter_q + {{(OFFSET_WIDTH - 1){1'b0}}, 1'b1};

  icache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_lines (
    .clk_i     (clk_in),
    .clear_i   (rst_in),
    .rdIndex_i (qIndex),
    .rdOffset_i(qOffset),
    .rdValid_o (rdValid),
    .rdTag_o   (rdTag),
    .rdWord_o  (rdWord),
    .wrEn_i    (beat),
    .wrIndex_i (pcIndex),
    .wrOffset_i(counter_q),
    .wrData_i  (mem.mem_resp_data),
    .setValid_i(lastBeat),
    .setIndex_i(pcIndex),
    .setTag_i  (pcTag)
  );

  // Controller: IDLE looks up accepted queries and answers hits directly;
  // misses walk the line in REFILL word by word, capturing the requested word
  // on the fly, and RESPOND emits the single response unless the query was
  // flushed while the refill was in flight. All outputs are registered here.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      counter_q     <= '0;
      killed_q      <= 1'b0;
      respWord_q    <= '0;
      dataEn_q      <= 1'b0;
      addrConfirm_q <= '0;
      data_q        <= '0;
      memReqEn_q    <= 1'b0;
      memReqAddr_q  <= '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          dataEn_q <= 1'b0;
          killed_q <= 1'b0;
          if (accept) begin
            pc_q <= fetch.query_pc;
            if (hit) begin
              dataEn_q      <= 1'b1;
              data_q        <= rdWord;
              addrConfirm_q <= fetch.query_pc;
            end else begin
              state_q      <= REFILL;
              counter_q    <= '0;
              memReqEn_q   <= 1'b1;
              memReqAddr_q <= lineBase;
            end
          end
        end
        REFILL: begin
          if (fetch.flush_in) begin
            killed_q <= 1'b1;
          end
          if (mem.mem_resp_en) begin
            if (counter_q == pcOffset) begin
              respWord_q <= mem.mem_resp_data;
            end
            if (counter_q == LAST_WORD) begin
              memReqEn_q <= 1'b0;
              state_q    <= RESPOND;
            end else begin
              counter_q    <= counterInc;
              memReqAddr_q <= memReqAddr_q + 32'd4;
            end
          end
        end
        RESPOND: begin
          if (!killed_q && !fetch.flush_in) begin
            dataEn_q      <= 1'b1;
            data_q        <= respWord_q;
            addrConfirm_q <= pc_q;
          end
          killed_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fetch.data_en      = dataEn_q;
  assign fetch.addr_confirm = addrConfirm_q;
  assign fetch.data         = data_q;
  assign mem.mem_req_en     = memReqEn_q;
  assign mem.mem_req_addr   = memReqAddr_q;

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache
// Directed self-checking bench for icache. The bench plays both the fetcher
// and the memory controller; memory returns 0x1000 + address for every word.
// Inputs change on the falling edge and outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_icache;

  logic clk;
  logic rst;
  logic rdy;

  int checks = 0;
  int errors = 0;

  icache_fetch_if fetchIf ();
  icache_mem_if   memIf ();

  icache dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .fetch (fetchIf),
    .mem   (memIf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive the fetcher side of the cache.
  task automatic applyStimulus(input logic qEn, input logic [31:0] pc,
                               input logic flush);
    fetchIf.query_en = qEn;
    fetchIf.query_pc = pc;
    fetchIf.flush_in = flush;
  endtask

  // Memory side: wait (bounded) for a request, check its address, return one
  // word for one cycle, then leave one idle cycle.
  task automatic serveWord(input string tag, input logic [31:0] expAddr);
    int n = 0;
    while (!memIf.mem_req_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " req_en"}, 32'(memIf.mem_req_en), 32'd1);
    checkOutput({tag, " req_addr"}, memIf.mem_req_addr, expAddr);
    memIf.mem_resp_en   = 1'b1;
    memIf.mem_resp_data = 32'h1000 + expAddr;
    @(negedge clk);
    memIf.mem_resp_en   = 1'b0;
    memIf.mem_resp_data = 32'h0;
    @(negedge clk);
  endtask

  // Full four-word refill of the line starting at base.
  task automatic serveLine(input string tag, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      serveWord(tag, base + 32'(4 * i));
    end
  endtask

  // Response cycle expectations.
  task automatic checkRespond(input string tag, input logic [31:0] pc,
                              input logic [31:0] word);
    checkOutput({tag, " data_en"}, 32'(fetchIf.data_en), 32'd1);
    checkOutput({tag, " data"}, fetchIf.data, word);
    checkOutput({tag, " addr_confirm"}, fetchIf.addr_confirm, pc);
    checkOutput({tag, " no mem_req"}, 32'(memIf.mem_req_en), 32'd0);
  endtask

  // Directed sequence covering cold miss, hit, held query, conflict miss,
  // flush during refill, ready pause and reset during refill.
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    memIf.mem_resp_en   = 1'b0;
    memIf.mem_resp_data = 32'h0;
    repeat (2) @(negedge clk);

    checkOutput("reset data_en", 32'(fetchIf.data_en), 32'd0);
    checkOutput("reset mem_req_en", 32'(memIf.mem_req_en), 32'd0);
    checkOutput("reset addr_confirm", fetchIf.addr_confirm, 32'h0);
    checkOutput("reset data", fetchIf.data, 32'h0);
    checkOutput("reset mem_req_addr", memIf.mem_req_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] cold miss pc=0x0");
    applyStimulus(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cold data_en low", 32'(fetchIf.data_en), 32'd0);
    serveLine("cold", 32'h0);
    checkRespond("cold", 32'h0, 32'h1000);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("cold pulse end", 32'(fetchIf.data_en), 32'd0);

    $display("[TB] hit pc=0x8");
    applyStimulus(1'b1, 32'h8, 1'b0);
    @(negedge clk);
    checkRespond("hit8", 32'h8, 32'h1008);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("hit8 pulse end", 32'(fetchIf.data_en), 32'd0);

    $display("[TB] held query pc=0xC");
    applyStimulus(1'b1, 32'hC, 1'b0);
    @(negedge clk);
    checkRespond("held", 32'hC, 32'h100C);
    @(negedge clk);
    checkOutput("held no second pulse", 32'(fetchIf.data_en), 32'd0);
    checkOutput("held no mem_req", 32'(memIf.mem_req_en), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("held idle", 32'(fetchIf.data_en), 32'd0);

    $display("[TB] conflict pc=0x100");
    applyStimulus(1'b1, 32'h100, 1'b0);
    @(negedge clk);
    checkOutput("conflict data_en low", 32'(fetchIf.data_en), 32'd0);
    serveLine("conflict", 32'h100);
    checkRespond("conflict", 32'h100, 32'h1100);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("evicted miss data_en", 32'(fetchIf.data_en), 32'd0);
    serveLine("evicted", 32'h0);
    checkRespond("evicted", 32'h0, 32'h1000);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);

    $display("[TB] flush during refill pc=0x24");
    applyStimulus(1'b1, 32'h24, 1'b0);
    @(negedge clk);
    serveWord("flush", 32'h20);
    serveWord("flush", 32'h24);
    applyStimulus(1'b0, 32'h24, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h24, 1'b0);
    serveWord("flush", 32'h28);
    serveWord("flush", 32'h2C);
    checkOutput("flush no data_en", 32'(fetchIf.data_en), 32'd0);
    checkOutput("flush req done", 32'(memIf.mem_req_en), 32'd0);
    applyStimulus(1'b1, 32'h24, 1'b0);
    @(negedge clk);
    checkRespond("after flush hit", 32'h24, 32'h1024);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);

    $display("[TB] pause and reset during refill pc=0x30");
    applyStimulus(1'b1, 32'h30, 1'b0);
    @(negedge clk);
    serveWord("pause", 32'h30);
    rdy = 1'b0;
    memIf.mem_resp_en   = 1'b1;
    memIf.mem_resp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("pause frozen addr", memIf.mem_req_addr, 32'h34);
      checkOutput("pause req held", 32'(memIf.mem_req_en), 32'd1);
    end
    rdy = 1'b1;
    memIf.mem_resp_en   = 1'b0;
    memIf.mem_resp_data = 32'h0;
    serveWord("resume", 32'h34);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("midreset mem_req_en", 32'(memIf.mem_req_en), 32'd0);
    checkOutput("midreset mem_req_addr", memIf.mem_req_addr, 32'h0);
    checkOutput("midreset data_en", 32'(fetchIf.data_en), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h8, 1'b0);
    @(negedge clk);
    checkOutput("post-reset miss data_en", 32'(fetchIf.data_en), 32'd0);
    serveLine("post-reset", 32'h0);
    checkRespond("post-reset", 32'h8, 32'h1008);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
